ext_mem_req_arbiter: RTL

//  Shares the single external memory request/response port between the demand-miss path (miss handler) and
//  the next-line prefetcher. One block transaction is in flight at a time. Demand has fixed priority, with a

---
 rtl/ext_mem_req_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ext_mem_req_arbiter.sv
// Shares one external memory request/response port between the demand-miss path and the
// next-line prefetcher. One block transaction in flight; demand has priority with a
// starvation guard for prefetch; a watchdog aborts stalled transactions.
module ext_mem_req_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 40,
  parameter int unsigned BEATS_PER_BLOCK = 8,
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_dmd_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_dmd_req_addr,
  input  logic                  i_pf_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_pf_req_addr,
  output logic                  o_dmd_gnt,
  output logic                  o_pf_gnt,
  output logic                  o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_data_valid,
  output logic                  o_mem_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_dmd_rsp_valid,
  output logic                  o_pf_rsp_valid,
  output logic                  o_dmd_done,
  output logic                  o_pf_done,
  output logic                  o_timeout,
  output logic                  o_busy
);

  localparam int unsigned BeatW = $clog2(BEATS_PER_BLOCK);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [BeatW-1:0] LastBeat  = BeatW'(BEATS_PER_BLOCK - 1);
  localparam logic [TmoW-1:0]  TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       StarveMax = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;  // 1: prefetch owns the transaction
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [2:0]            starve_q, starve_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  dmd_rsp_valid_q, dmd_rsp_valid_d;
  logic                  pf_rsp_valid_q, pf_rsp_valid_d;
  logic                  dmd_done_q, dmd_done_d;
  logic                  pf_done_q, pf_done_d;
  logic                  timeout_q, timeout_d;
  logic                  pick_pf;

  // Next-state, arbitration, beat handling and combinational port outputs.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    starve_d        = starve_q;
    tmo_d           = tmo_q;
    rsp_data_d      = rsp_data_q;
    dmd_rsp_valid_d = 1'b0;
    pf_rsp_valid_d  = 1'b0;
    dmd_done_d      = 1'b0;
    pf_done_d       = 1'b0;
    timeout_d       = 1'b0;
    o_dmd_gnt       = 1'b0;
    o_pf_gnt        = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    pick_pf         = i_pf_req_valid & (~i_dmd_req_valid | (starve_q == StarveMax));

    if (i_halt) begin
      // Everything else holds; the response-side registers clear.
      rsp_data_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_dmd_req_valid || i_pf_req_valid) begin
            owner_d = pick_pf;
            addr_d  = pick_pf ? i_pf_req_addr : i_dmd_req_addr;
            if (pick_pf || !i_pf_req_valid) begin
              starve_d = '0;
            end else if (starve_q != StarveMax) begin
              starve_d = starve_q + 3'd1;
            end
            state_d = StIssue;
          end
        end
        StIssue: begin
          o_mem_req_valid = 1'b1;
          o_mem_req_addr  = addr_q;
          o_dmd_gnt       = ~owner_q;
          o_pf_gnt        = owner_q;
          tmo_d           = '0;
          state_d         = StWait;
        end
        StWait: begin
          if (i_mem_data_valid) begin
            // A beat on the final watchdog cycle wins over the abort.
            rsp_data_d      = i_mem_data;
            dmd_rsp_valid_d = ~owner_q;
            pf_rsp_valid_d  = owner_q;
            tmo_d           = '0;
            if (beat_q == LastBeat) begin
              dmd_done_d = ~owner_q;
              pf_done_d  = owner_q;
              beat_d     = '0;
              state_d    = StIdle;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end else if (tmo_q == TmoLast) begin
            timeout_d = 1'b1;
            beat_d    = '0;
            tmo_d     = '0;
            state_d   = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered-output flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= StIdle;
      owner_q         <= 1'b0;
      addr_q          <= '0;
      beat_q          <= '0;
      starve_q        <= '0;
      tmo_q           <= '0;
      rsp_data_q      <= '0;
      dmd_rsp_valid_q <= 1'b0;
      pf_rsp_valid_q  <= 1'b0;
      dmd_done_q      <= 1'b0;
      pf_done_q       <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      starve_q        <= starve_d;
      tmo_q           <= tmo_d;
      rsp_data_q      <= rsp_data_d;
      dmd_rsp_valid_q <= dmd_rsp_valid_d;
      pf_rsp_valid_q  <= pf_rsp_valid_d;
      dmd_done_q      <= dmd_done_d;
      pf_done_q       <= pf_done_d;
      timeout_q       <= timeout_d;
    end
  end

  assign o_mem_ready     = (state_q == StWait) & ~i_halt;
  assign o_busy          = (state_q != StIdle);
  assign o_rsp_data      = rsp_data_q;
  assign o_dmd_rsp_valid = dmd_rsp_valid_q;
  assign o_pf_rsp_valid  = pf_rsp_valid_q;
  assign o_dmd_done      = dmd_done_q;
  assign o_pf_done       = pf_done_q;
  assign o_timeout       = timeout_q;

endmodule
